// File: rtl/motion_sequencer.sv
// Two-axis stepper sequencer: APB3 command FIFO feeding a Bresenham pulse generator.
// Each command is {dx, dy} plus the PERIOD captured when it was pushed.
module motion_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PULSE_W    = 100
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        step1,
    output logic        dir1,
    output logic        step2,
    output logic        dir2,
    output logic        busy,
    output logic        irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [23:0] MIN_PERIOD = 24'(2 * PULSE_W);
    localparam logic [23:0] PW_LAST    = 24'(PULSE_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_GAP} state_t;

    logic [55:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [23:0]      period_q;
    logic             overflow_q, done_q, irq_en_q;

    state_t              state_q;
    logic [23:0]         timer_q, eff_q;
    logic [16:0]         remaining_q, major_q, minor_q;
    logic                x_major_q;
    logic signed [17:0]  err_q;
    logic                step1_q, step2_q, dir1_q, dir2_q;

    // APB decode
    logic       acc, cmd_wr, per_wr, ctrl_wr, abort;
    logic [1:0] reg_sel;
    logic       fifo_full, fifo_empty, push, pop;
    logic       unused_ok;

    assign reg_sel   = PADDR[3:2];
    assign acc       = PSEL & PENABLE;
    assign cmd_wr    = acc & PWRITE & (reg_sel == 2'd0);
    assign per_wr    = acc & PWRITE & (reg_sel == 2'd1);
    assign ctrl_wr   = acc & PWRITE & (reg_sel == 2'd3);
    assign abort     = ctrl_wr & PWDATA[0];
    assign unused_ok = ^{PADDR[31:4], PADDR[1:0]};

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = cmd_wr & ~fifo_full & ~abort;
    assign pop        = (state_q == S_LOAD) & ~abort;

    assign PREADY  = 1'b1;
    assign PSLVERR = cmd_wr & fifo_full;

    // Head entry decode, used only in LOAD
    logic [55:0] ent;
    logic [15:0] ent_dx, ent_dy;
    logic [23:0] ent_per, eff_c;
    logic [16:0] ax_c, ay_c, major_c, minor_c;
    logic        x_major_c;

    assign ent       = fifo_mem[rd_ptr_q];
    assign ent_dy    = ent[55:40];
    assign ent_dx    = ent[39:24];
    assign ent_per   = ent[23:0];
    assign ax_c      = ent_dx[15] ? (17'd0 - {1'b1, ent_dx}) : {1'b0, ent_dx};
    assign ay_c      = ent_dy[15] ? (17'd0 - {1'b1, ent_dy}) : {1'b0, ent_dy};
    assign x_major_c = (ax_c >= ay_c);
    assign major_c   = x_major_c ? ax_c : ay_c;
    assign minor_c   = x_major_c ? ay_c : ax_c;
    assign eff_c     = (ent_per < MIN_PERIOD) ? MIN_PERIOD : ent_per;

    // Bresenham step decision for the pulse about to start
    logic signed [17:0] err_sub, err_d;
    logic               minor_hit, step1_start, step2_start;
    logic               pulse_end, gap_end, done_set;

    assign err_sub     = err_q - $signed({1'b0, minor_q});
    assign minor_hit   = err_sub[17];
    assign err_d       = minor_hit ? (err_sub + $signed({1'b0, major_q})) : err_sub;
    assign step1_start = x_major_q | minor_hit;
    assign step2_start = ~x_major_q | minor_hit;
    assign pulse_end   = (timer_q == PW_LAST);
    assign gap_end     = (timer_q == eff_q - 24'd1);
    assign done_set    = (state_q == S_GAP) & gap_end & (remaining_q == 17'd1)
                       & fifo_empty & ~abort;

    always_ff @(posedge PCLK) begin
        if (push) fifo_mem[wr_ptr_q] <= {PWDATA, period_q};
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN || abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            period_q   <= 24'd1000;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            if (per_wr) period_q <= PWDATA[23:0];
            if (ctrl_wr) begin
                irq_en_q <= PWDATA[2];
                if (PWDATA[1]) overflow_q <= 1'b0;
                if (PWDATA[3]) done_q <= 1'b0;
            end
            if (cmd_wr && fifo_full) overflow_q <= 1'b1;
            if (done_set) done_q <= 1'b1;
        end
    end

    // Timer counts from pulse start, so the GAP end marks one full period
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            eff_q       <= '0;
            remaining_q <= '0;
            major_q     <= '0;
            minor_q     <= '0;
            x_major_q   <= 1'b0;
            err_q       <= '0;
            step1_q     <= 1'b0;
            step2_q     <= 1'b0;
            dir1_q      <= 1'b0;
            dir2_q      <= 1'b0;
        end else if (abort) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            step1_q     <= 1'b0;
            step2_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    dir1_q      <= ent_dx[15];
                    dir2_q      <= ent_dy[15];
                    major_q     <= major_c;
                    minor_q     <= minor_c;
                    x_major_q   <= x_major_c;
                    err_q       <= $signed({1'b0, major_c >> 1});
                    eff_q       <= eff_c;
                    remaining_q <= major_c;
                    timer_q     <= '0;
                    if (major_c == '0)
                        state_q <= (count_q > CNT_W'(1)) ? S_LOAD : S_IDLE;
                    else
                        state_q <= S_SETUP;
                end
                S_SETUP: begin
                    timer_q <= timer_q + 24'd1;
                    if (pulse_end) begin
                        state_q <= S_PULSE;
                        timer_q <= '0;
                        err_q   <= err_d;
                        step1_q <= step1_start;
                        step2_q <= step2_start;
                    end
                end
                S_PULSE: begin
                    timer_q <= timer_q + 24'd1;
                    if (pulse_end) begin
                        state_q <= S_GAP;
                        step1_q <= 1'b0;
                        step2_q <= 1'b0;
                    end
                end
                S_GAP: begin
                    timer_q <= timer_q + 24'd1;
                    if (gap_end) begin
                        remaining_q <= remaining_q - 17'd1;
                        if (remaining_q > 17'd1) begin
                            state_q <= S_PULSE;
                            timer_q <= '0;
                            err_q   <= err_d;
                            step1_q <= step1_start;
                            step2_q <= step2_start;
                        end else begin
                            state_q <= fifo_empty ? S_IDLE : S_LOAD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign step1 = step1_q;
    assign step2 = step2_q;
    assign dir1  = dir1_q;
    assign dir2  = dir2_q;
    assign busy  = (state_q != S_IDLE) | ~fifo_empty;
    assign irq   = irq_en_q & done_q;

    logic [4:0] cnt5;
    assign cnt5 = 5'(count_q);

    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            unique case (reg_sel)
                2'd0: PRDATA = {15'd0, remaining_q};
                2'd1: PRDATA = {8'd0, period_q};
                2'd2: PRDATA = {22'd0, done_q, overflow_q, cnt5, fifo_empty, fifo_full, busy};
                default: PRDATA = {29'd0, irq_en_q, 2'd0};
            endcase
        end
    end
endmodule

// File: tb/tb_motion_sequencer.sv
// Bench for motion_sequencer: directed scenarios plus randomized moves checked against
// per-axis pulse counts, directions, widths and spacing derived from each command.
module tb_motion_sequencer;
    localparam int PW = 4;
    localparam int DEPTH = 4;

    logic        PCLK = 1'b0, PRESERN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, step1, dir1, step2, dir2, busy, irq;

    motion_sequencer #(.FIFO_DEPTH(DEPTH), .PULSE_W(PW)) dut (
        .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .step1(step1), .dir1(dir1), .step2(step2), .dir2(dir2), .busy(busy), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    int tests = 0, fails = 0;

    // Pulse monitor
    int cyc = 0;
    int n1, n2, w1, w2, wmin, wmax;
    int r1[$], r2[$], evlog[$];
    logic p1 = 1'b0, p2 = 1'b0;

    always @(posedge PCLK) cyc++;

    always @(negedge PCLK) begin
        if (step1 && !p1) begin n1++; r1.push_back(cyc); evlog.push_back(0 + int'(dir1)); end
        if (step2 && !p2) begin n2++; r2.push_back(cyc); evlog.push_back(2 + int'(dir2)); end
        if (step1) w1 = p1 ? w1 + 1 : 1;
        if (step2) w2 = p2 ? w2 + 1 : 1;
        if (!step1 && p1) begin if (w1 < wmin) wmin = w1; if (w1 > wmax) wmax = w1; end
        if (!step2 && p2) begin if (w2 < wmin) wmin = w2; if (w2 > wmax) wmax = w2; end
        p1 = step1;
        p2 = step2;
    end

    task automatic clr_mon();
        n1 = 0; n2 = 0; wmin = 9999; wmax = 0;
        r1.delete(); r2.delete(); evlog.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = {28'd0, addr}; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1;
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] d; logic e;
        apb(1'b1, addr, data, d, e);
    endtask

    task automatic rd(input logic [3:0] addr, output logic [31:0] data);
        logic e;
        apb(1'b0, addr, 32'd0, data, e);
    endtask

    function automatic logic [31:0] cmd(input int dx, input int dy);
        logic [15:0] x, y;
        x = 16'(dx); y = 16'(dy);
        return {y, x};
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 4000) begin @(negedge PCLK); n++; end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Expected behaviour of one move, from the command alone
    task automatic check_move(input string tag, input int dx, input int dy, input int per);
        int ax, ay, eff, bad_sp, bad_dir;
        int maj[$], mnr[$];
        ax = dx < 0 ? -dx : dx;
        ay = dy < 0 ? -dy : dy;
        eff = per < 2 * PW ? 2 * PW : per;
        chk({tag, "_n1"}, n1, ax);
        chk({tag, "_n2"}, n2, ay);
        if (ax + ay > 0) begin
            chk({tag, "_wmin"}, wmin, PW);
            chk({tag, "_wmax"}, wmax, PW);
            if (ax >= ay) begin maj = r1; mnr = r2; end else begin maj = r2; mnr = r1; end
            bad_sp = 0;
            for (int i = 1; i < maj.size(); i++)
                if (maj[i] - maj[i-1] != eff) bad_sp++;
            foreach (mnr[i])
                if (maj.size() == 0 || mnr[i] < maj[0] || (mnr[i] - maj[0]) % eff != 0) bad_sp++;
            chk({tag, "_spacing"}, bad_sp, 0);
            bad_dir = 0;
            foreach (evlog[i])
                if ((evlog[i] < 2 && (evlog[i] % 2) != int'(dx < 0)) ||
                    (evlog[i] >= 2 && (evlog[i] % 2) != int'(dy < 0))) bad_dir++;
            chk({tag, "_dir"}, bad_dir, 0);
        end
    endtask

    task automatic run_cmd(input string tag, input int dx, input int dy, input int per,
                           input int mid_per);
        logic [31:0] st;
        wr(4'h4, per);
        clr_mon();
        wr(4'h0, cmd(dx, dy));
        wr(4'h4, mid_per);
        wait_idle({tag, "_idle"});
        repeat (2) @(negedge PCLK);
        check_move(tag, dx, dy, per);
        if (dx != 0 || dy != 0) begin
            rd(4'h8, st);
            chk({tag, "_done"}, {31'd0, st[9]}, 32'd1);
        end
        wr(4'hC, 32'd8);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          dxs[6], dys[6];
        int          exp_log[$];
        int          pending, errs_bad, mism, n;

        clr_mon();
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_pins", {26'd0, step1, step2, dir1, dir2, busy, irq}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_pready_slverr", {30'd0, PREADY, PSLVERR}, 32'd2);
        @(negedge PCLK);
        PRESERN = 1'b1;
        rd(4'h4, d); chk("rst_period", d, 32'd1000);
        rd(4'h8, d); chk("rst_status", d, 32'h4);
        rd(4'h0, d); chk("rst_remaining", d, 32'd0);

        // 5 x by 3 y at period 20; mid-move PERIOD change must not matter
        run_cmd("m5x3", 5, 3, 20, 5);
        chk("m5x3_dirs", {30'd0, dir1, dir2}, 32'd0);
        run_cmd("m-3x-7", -3, -7, 20, 50);
        chk("m-3x-7_dirs", {30'd0, dir1, dir2}, 32'd3);

        // irq follows enable & done
        wr(4'hC, 32'd4);
        wr(4'h4, 32'd8);
        clr_mon();
        wr(4'h0, cmd(1, 0));
        wait_idle("irq_idle");
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd(4'hC, d); chk("irq_en_read", d, 32'd4);
        wr(4'hC, 32'd12);
        chk("irq_clr", {31'd0, irq}, 32'd0);
        rd(4'h8, d); chk("done_clr", {31'd0, d[9]}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            int dx, dy, per;
            dx  = int'($urandom_range(0, 12)) - 6;
            dy  = int'($urandom_range(0, 12)) - 6;
            per = int'($urandom_range(1, 24));
            run_cmd($sformatf("rnd%0d", i), dx, dy, per, int'($urandom_range(1, 40)));
        end

        // zero move followed by a 2-step move; PERIOD=1 clamps to 2*PW
        wr(4'h4, 32'd1);
        clr_mon();
        wr(4'h0, cmd(0, 0));
        wr(4'h0, cmd(2, 0));
        wait_idle("zero_idle");
        repeat (2) @(negedge PCLK);
        check_move("zero_then2", 2, 0, 1);
        wr(4'hC, 32'd8);

        // overflow: long move running, then five pushes into a 4-deep FIFO
        dxs = '{3, 1, 0, -1, 0, 2};
        dys = '{0, 0, 1, 0, -2, 2};
        wr(4'h4, 32'd20);
        clr_mon();
        wr(4'h0, cmd(dxs[0], dys[0]));
        exp_log.delete();
        pending = 0; errs_bad = 0;
        for (int k = 0; k < 3; k++) exp_log.push_back(0);
        for (int c = 1; c < 6; c++) begin
            bit accept;
            apb(1'b1, 4'h0, cmd(dxs[c], dys[c]), d, e);
            accept = pending < DEPTH;
            if (e !== !accept) errs_bad++;
            if (accept) begin
                pending++;
                for (int k = 0; k < (dxs[c] < 0 ? -dxs[c] : dxs[c]); k++)
                    exp_log.push_back(int'(dxs[c] < 0));
                for (int k = 0; k < (dys[c] < 0 ? -dys[c] : dys[c]); k++)
                    exp_log.push_back(2 + int'(dys[c] < 0));
            end
        end
        chk("ovf_pslverr", errs_bad, 0);
        rd(4'h8, d);
        chk("ovf_status", {22'd0, d[9:1]}, {22'd0, 1'b0, 1'b1, 5'(DEPTH), 1'b0, 1'b1});
        wait_idle("ovf_idle");
        repeat (2) @(negedge PCLK);
        chk("ovf_log_len", evlog.size(), exp_log.size());
        mism = 0;
        foreach (exp_log[i])
            if (i >= evlog.size() || evlog[i] != exp_log[i]) mism++;
        chk("ovf_log_order", mism, 0);
        wr(4'hC, 32'd10);
        rd(4'h8, d); chk("ovf_cleared", d, 32'h4);

        // abort in the 2nd pulse of a 10-step move
        wr(4'h4, 32'd20);
        clr_mon();
        wr(4'h0, cmd(10, 0));
        n = 0;
        while (!(n1 == 2 && step1) && n < 2000) begin @(negedge PCLK); n++; end
        chk("abort_reach_pulse2", {31'd0, step1}, 32'd1);
        wr(4'hC, 32'd1);
        chk("abort_step_low", {30'd0, step1, step2}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rd(4'h8, d); chk("abort_status", d, 32'h4);
        rd(4'h0, d); chk("abort_remaining", d, 32'd0);
        repeat (60) @(negedge PCLK);
        chk("abort_no_more_pulses", n1, 2);

        // reset during a pulse
        clr_mon();
        wr(4'h0, cmd(3, 0));
        n = 0;
        while (!step1 && n < 2000) begin @(negedge PCLK); n++; end
        chk("rst_mid_reach", {31'd0, step1}, 32'd1);
        PRESERN = 1'b0;
        @(posedge PCLK); #1;
        chk("rst_mid_step", {30'd0, step1, step2}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge PCLK);
        PRESERN = 1'b1;
        rd(4'h4, d); chk("rst_mid_period", d, 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/motion_sequencer.md
MOTION_SEQUENCER -- requirements
Module: motion_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter PULSE_W, default 100: step pulse high time, in PCLK cycles.
REQ-003 SHALL have a single clock and a synchronous, active-low reset; all state SHALL update on PCLK rising edge only.
REQ-004 PCLK  in  1  fabric clock.
REQ-005 PRESERN  in  1  synchronous active-low reset.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB3 slave controls.
REQ-007 PADDR  in  32  byte address; only [3:2] decoded.
REQ-008 PWDATA  in  32  write data.
REQ-009 PRDATA  out  32  read data; PREADY out 1; PSLVERR out 1.
REQ-010 step1, dir1, step2, dir2  out  1 each  stepper driver pins; axis 1 = X, axis 2 = Y.
REQ-011 busy  out  1  high while a move executes or FIFO non-empty; irq  out  1  level interrupt.

Function
REQ-012 APB: PREADY SHALL be 1 constantly; access commits when PSEL&PENABLE; reads are combinational from registers.
REQ-013 0x0 CMD write: {dy[31:16], dx[15:0]}, both signed; SHALL push {dx, dy, PERIOD} into the FIFO. Read: remaining major-axis steps of the current move, zero-extended.
REQ-014 0x4 PERIOD R/W [23:0] cycles per major step, reset 24'd1000; effective period = max(PERIOD, 2*PULSE_W).
REQ-015 0x8 STATUS RO: [0] busy, [1] full, [2] empty, [7:3] count, [8] overflow, [9] done.
REQ-016 0xC CTRL W: [0] abort, [1] clear overflow, [2] irq enable (sticky, readable at [2]), [3] clear done.
REQ-017 CMD write when full SHALL be dropped, set overflow, and assert PSLVERR during that access phase; all other accesses SHALL have PSLVERR=0.
REQ-018 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-019 FSM states: IDLE, LOAD, SETUP, PULSE, GAP.
REQ-020 IDLE -> LOAD when FIFO non-empty.
REQ-021 LOAD (1 cycle): pop the entry; dirN = sign bit of d; ax=|dx|, ay=|dy| (17-bit; -32768 -> 32768); major = max(ax,ay); X is major on tie; err = major>>1.
REQ-022 LOAD: major==0 SHALL go to IDLE (or LOAD again if non-empty) with no pulses; otherwise -> SETUP.
REQ-023 SETUP: hold step low for PULSE_W cycles (dir setup time) -> PULSE.
REQ-024 PULSE entry: major-axis step high; err -= minor; if result < 0, err += major and minor-axis step high; both stay high PULSE_W cycles -> GAP.
REQ-025 GAP: steps low until effective period elapsed since pulse start; remaining decrements; remaining>0 -> PULSE, else LOAD if non-empty, else IDLE and set done.
REQ-026 Over a move, exactly ax pulses on step1 and ay pulses on step2.
REQ-027 dir outputs SHALL change only in LOAD.
REQ-028 Abort SHALL, next cycle: drive step1/step2 low, flush FIFO, zero remaining, enter IDLE; done is not set. Abort and CMD push in the same access: abort wins, push discarded.
REQ-029 PERIOD writes mid-move SHALL affect only subsequently pushed commands.
REQ-030 irq = irq_enable & done.

Reset
REQ-031 PRESERN low SHALL force: FSM IDLE; FIFO empty; step1/2=0, dir1/2=0; busy=0; irq=0; overflow, done, irq_enable=0; PERIOD=1000; remaining=0; PRDATA=0 when not selected.
REQ-032 Reset mid-pulse SHALL drop step outputs the cycle after reset is sampled.

Verification
REQ-033 PULSE_W=4, PERIOD=20, CMD dx=5 dy=3 -> 5 step1, 3 step2 pulses, each 4 cycles high, 20-cycle spacing, dir1=dir2=0, done=1.
REQ-034 CMD dx=-3 dy=-7 -> dir1=dir2=1 before first pulse, 7 step2, 3 step1 pulses.
REQ-035 Push 5 commands with FIFO_DEPTH=4 while busy -> 5th access has PSLVERR=1, overflow=1; first 4 execute in order.
REQ-036 Abort during the 2nd pulse of a 10-step move -> step low next cycle, count=0, busy=0, done=0.
REQ-037 CMD dx=0 dy=0 followed by dx=2 dy=0 -> no pulses for first, 2 step1 pulses for second; PERIOD=1 with PULSE_W=4 -> 8-cycle spacing.
